fb_writer: RTL and testbench

FB_WRITER -- requirements
Module: fb_writer

---
 rtl/gpu_pkg.sv | 16 +
 rtl/fb_writer_if.sv | 29 ++
 rtl/sync_fifo.sv | 46 ++++
 rtl/fb_writer.sv | 128 ++++++++++++
 tb/tb_fb_writer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU constants and the packed pixel-beat carried through the writer's skid FIFO.
package gpu_pkg;
  localparam int COORD_W   = 11;
  localparam int COLOR_W   = 8;
  localparam int PIX_IDX_W = 22;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
    logic               frame_end;
    logic               draw;
  } pix_beat_t;
endpackage

// File: rtl/fb_writer_if.sv
// Pixel stream (GPU -> writer) and framebuffer write bus (writer -> memory).
interface fb_pix_if;
  import gpu_pkg::*;
  logic [COLOR_W-1:0] in_color;
  logic               in_valid;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic [COORD_W-1:0] in_width;
  logic [COORD_W-1:0] in_height;
  logic               in_frame_end;
  logic               in_draw;
  logic               in_ready;

  modport master (output in_color, in_valid, in_x, in_y, in_width, in_height,
                  in_frame_end, in_draw, input in_ready);
  modport slave  (input in_color, in_valid, in_x, in_y, in_width, in_height,
                  in_frame_end, in_draw, output in_ready);
endinterface

interface fb_mem_if #(parameter int ADDR_W = 23);
  import gpu_pkg::*;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               fb_we;
  logic               fb_ack;

  modport master (output fb_addr, fb_data, fb_we, input fb_ack);
  modport slave  (input fb_addr, fb_data, fb_we, output fb_ack);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; push ignored when full, pop when empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fb_writer.sv
// Double-buffered framebuffer writer: skid FIFO -> index/clip stage -> held write stage,
// with a RUN/DRAIN/SWAP sequencer that flips buffers once all writes of a frame land.
module fb_writer
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 23
) (
  input  logic        clk,
  input  logic        reset,
  fb_pix_if.slave     pix,
  fb_mem_if.master    mem,
  output logic        front_buf,
  output logic        frame_done,
  output logic [15:0] clip_count
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] SWAP  = 2'd2;

  pix_beat_t            in_beat, head;
  logic                 fifo_full, fifo_empty, push, pop, adv;
  logic                 head_clip;
  logic [PIX_IDX_W-1:0] head_idx;

  logic [1:0]           state_q, state_d;
  logic                 front_q;
  logic [15:0]          clip_q;
  logic                 s1_vld_q, s1_wr_q;
  logic [PIX_IDX_W-1:0] s1_idx_q;
  logic [COLOR_W-1:0]   s1_color_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COLOR_W-1:0]   data_q;

  assign in_beat = '{color: pix.in_color, x: pix.in_x, y: pix.in_y,
                     width: pix.in_width, height: pix.in_height,
                     frame_end: pix.in_frame_end, draw: pix.in_draw};

  assign pix.in_ready = !fifo_full && !reset;
  // Pure skip beats carry nothing the writer needs, so they never occupy a slot.
  assign push = pix.in_valid && pix.in_ready && (pix.in_draw || pix.in_frame_end);

  sync_fifo #(.W($bits(pix_beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (in_beat),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A held write blocks everything upstream.
  assign adv       = !(we_q && !mem.fb_ack);
  assign pop       = adv && !fifo_empty && (state_q == RUN);
  assign head_clip = (head.x >= head.width) || (head.y >= head.height);
  assign head_idx  = PIX_IDX_W'(head.y) * PIX_IDX_W'(head.width) + PIX_IDX_W'(head.x);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_wr_q    <= 1'b0;
      s1_idx_q   <= '0;
      s1_color_q <= '0;
    end else if (adv) begin
      s1_vld_q   <= pop;
      s1_wr_q    <= pop && head.draw && !head_clip;
      s1_idx_q   <= head_idx;
      s1_color_q <= head.color;
    end
  end

  always_comb begin
    addr_d                  = '0;
    addr_d[ADDR_W-1]        = ~front_q;
    addr_d[PIX_IDX_W-1:0]   = s1_idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (adv) begin
      we_q <= s1_wr_q;
      if (s1_wr_q) begin
        addr_q <= addr_d;
        data_q <= s1_color_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (pop && head.frame_end) state_d = DRAIN;
      DRAIN:   if (!s1_vld_q && !we_q) state_d = SWAP;
      SWAP:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Buffer flip and clip clear land on SWAP entry so they are visible with frame_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      front_q <= 1'b0;
      clip_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DRAIN && state_d == SWAP) begin
        front_q <= ~front_q;
        clip_q  <= '0;
      end else if (pop && head.draw && head_clip && clip_q != 16'hFFFF) begin
        clip_q  <= clip_q + 16'd1;
      end
    end
  end

  assign mem.fb_we   = we_q;
  assign mem.fb_addr = addr_q;
  assign mem.fb_data = data_q;
  assign front_buf   = front_q;
  assign frame_done  = (state_q == SWAP);
  assign clip_count  = clip_q;
endmodule

// File: tb/tb_fb_writer.sv
// Directed scenarios for fb_writer with hand-computed expectations.
module tb_fb_writer;
  logic        clk;
  logic        reset;
  logic        front_buf, frame_done;
  logic [15:0] clip_count;
  int          checks = 0;
  int          failures = 0;

  fb_pix_if               pix ();
  fb_mem_if #(.ADDR_W(23)) mem ();

  fb_writer #(.FIFO_DEPTH(16), .ADDR_W(23)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix        (pix),
    .mem        (mem),
    .front_buf  (front_buf),
    .frame_done (frame_done),
    .clip_count (clip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one beat and holds it until accepted; caller sits at posedge+1.
  task automatic send(input logic [7:0] c, input logic [10:0] x, input logic [10:0] y,
                      input logic fe, input logic dr);
    bit ok = 1'b0;
    pix.in_color = c; pix.in_x = x; pix.in_y = y;
    pix.in_frame_end = fe; pix.in_draw = dr; pix.in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = pix.in_ready;
      @(posedge clk); #1;
    end
    pix.in_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout got in_ready=0 for 200 cycles exp accept");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pix.in_valid = 1'b0; pix.in_draw = 1'b0; pix.in_frame_end = 1'b0;
    pix.in_x = '0; pix.in_y = '0; pix.in_color = '0;
    pix.in_width = 11'd640; pix.in_height = 11'd480; mem.fb_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pix.in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_low got %b exp 0", pix.in_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (pix.in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_high got %b exp 1", pix.in_ready); end
    checks++; if (mem.fb_we !== 1'b0) begin failures++; $display("FAIL rst_we got %b exp 0", mem.fb_we); end
    checks++; if (mem.fb_addr !== 23'd0) begin failures++; $display("FAIL rst_addr got %h exp 0", mem.fb_addr); end
    checks++; if (mem.fb_data !== 8'd0) begin failures++; $display("FAIL rst_data got %h exp 0", mem.fb_data); end
    checks++; if (front_buf !== 1'b0) begin failures++; $display("FAIL rst_front got %b exp 0", front_buf); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_done got %b exp 0", frame_done); end
    checks++; if (clip_count !== 16'd0) begin failures++; $display("FAIL rst_clip got %0d exp 0", clip_count); end
  endtask

  task automatic test_basic_write();
    send(8'h5A, 11'd10, 11'd2, 1'b0, 1'b1);
    checks++; if (mem.fb_we !== 1'b0) begin failures++; $display("FAIL lat_c1 got we=%b exp 0", mem.fb_we); end
    @(posedge clk); #1;
    checks++; if (mem.fb_we !== 1'b0) begin failures++; $display("FAIL lat_c2 got we=%b exp 0", mem.fb_we); end
    @(posedge clk); #1;
    checks++; if (mem.fb_we !== 1'b1) begin failures++; $display("FAIL lat_c3 got we=%b exp 1", mem.fb_we); end
    checks++; if (mem.fb_addr !== {1'b1, 22'd1290}) begin failures++; $display("FAIL basic_addr got %h exp %h", mem.fb_addr, {1'b1, 22'd1290}); end
    checks++; if (mem.fb_data !== 8'h5A) begin failures++; $display("FAIL basic_data got %h exp 5a", mem.fb_data); end
    @(posedge clk); #1;
    checks++; if (mem.fb_we !== 1'b0) begin failures++; $display("FAIL basic_we_drop got %b exp 0", mem.fb_we); end
  endtask

  task automatic test_clip();
    bit seen = 1'b0;
    bit fd = 1'b0;
    send(8'h11, 11'd640, 11'd0, 1'b0, 1'b1);
    send(8'h22, 11'd0, 11'd480, 1'b0, 1'b1);
    repeat (6) begin @(posedge clk); #1; if (mem.fb_we) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL clip_no_write got we seen exp none"); end
    checks++; if (clip_count !== 16'd2) begin failures++; $display("FAIL clip_count got %0d exp 2", clip_count); end
    send(8'h00, 11'd0, 11'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !fd; i++) begin @(posedge clk); #1; fd = frame_done; end
    checks++; if (fd !== 1'b1) begin failures++; $display("FAIL clip_swap got no frame_done exp pulse"); end
    checks++; if (front_buf !== 1'b1) begin failures++; $display("FAIL clip_front got %b exp 1", front_buf); end
    checks++; if (clip_count !== 16'd0) begin failures++; $display("FAIL clip_clear got %0d exp 0", clip_count); end
    @(posedge clk); #1;
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL done_pulse got %b exp 0", frame_done); end
    // Clipped pixel carrying the frame-end marker still swaps.
    seen = 1'b0; fd = 1'b0;
    send(8'h33, 11'd700, 11'd0, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !fd; i++) begin
      @(posedge clk); #1; fd = frame_done; if (mem.fb_we) seen = 1'b1;
    end
    checks++; if (fd !== 1'b1) begin failures++; $display("FAIL clipfe_swap got no frame_done exp pulse"); end
    checks++; if (front_buf !== 1'b0) begin failures++; $display("FAIL clipfe_front got %b exp 0", front_buf); end
    checks++; if (clip_count !== 16'd0) begin failures++; $display("FAIL clipfe_clear got %0d exp 0", clip_count); end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL clipfe_write got we seen exp none"); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int n = 0;
    int first = 0;
    int last = 0;
    bit rdy;
    mem.fb_ack = 1'b0;
    pix.in_y = 11'd0; pix.in_draw = 1'b1; pix.in_frame_end = 1'b0; pix.in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      pix.in_x = 11'(acc); pix.in_color = 8'(acc);
      rdy = pix.in_ready;
      @(posedge clk); #1;
      if (rdy) acc++;
    end
    pix.in_valid = 1'b0;
    checks++; if (acc !== 18) begin failures++; $display("FAIL bp_accepted got %0d exp 18", acc); end
    checks++; if (pix.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got %b exp 0", pix.in_ready); end
    checks++; if (mem.fb_we !== 1'b1 || mem.fb_addr !== {1'b1, 22'd0}) begin
      failures++; $display("FAIL bp_hold got we=%b addr=%h exp we=1 addr=%h", mem.fb_we, mem.fb_addr, {1'b1, 22'd0});
    end
    mem.fb_ack = 1'b1;
    for (int c = 0; c < 60 && n < 18; c++) begin
      if (mem.fb_we) begin
        checks++;
        if (mem.fb_addr !== {1'b1, 22'(n)} || mem.fb_data !== 8'(n)) begin
          failures++; $display("FAIL bp_order got addr=%h data=%h exp addr=%h data=%h", mem.fb_addr, mem.fb_data, {1'b1, 22'(n)}, 8'(n));
        end
        if (n == 0) first = c;
        last = c;
        n++;
      end
      @(posedge clk); #1;
    end
    checks++; if (n !== 18) begin failures++; $display("FAIL bp_count got %0d exp 18", n); end
    checks++; if (last - first !== 17) begin failures++; $display("FAIL bp_rate got span=%0d exp 17", last - first); end
  endtask

  task automatic test_frame_drain();
    logic [22:0] wa [8];
    int n = 0;
    int fd_cnt = 0;
    int fd_at = -1;
    logic fd_front = 1'b0;
    fork
      begin
        send(8'h01, 11'd1, 11'd0, 1'b0, 1'b1);
        send(8'h02, 11'd2, 11'd0, 1'b0, 1'b1);
        send(8'h03, 11'd3, 11'd0, 1'b0, 1'b1);
        send(8'h00, 11'd0, 11'd0, 1'b1, 1'b0);
        send(8'h05, 11'd5, 11'd0, 1'b0, 1'b1);
      end
      begin
        for (int c = 0; c < 80; c++) begin
          if (mem.fb_we && mem.fb_ack) begin
            if (n < 8) wa[n] = mem.fb_addr;
            n++;
          end
          if (frame_done) begin fd_cnt++; fd_at = n; fd_front = front_buf; end
          @(posedge clk); #1;
          mem.fb_ack = ~mem.fb_ack;
        end
      end
    join
    mem.fb_ack = 1'b1;
    checks++; if (n !== 4) begin failures++; $display("FAIL drain_writes got %0d exp 4", n); end
    checks++; if (fd_cnt !== 1) begin failures++; $display("FAIL drain_done_cnt got %0d exp 1", fd_cnt); end
    checks++; if (fd_at !== 3) begin failures++; $display("FAIL drain_order got done after %0d writes exp 3", fd_at); end
    checks++; if (fd_front !== 1'b1) begin failures++; $display("FAIL drain_front got %b exp 1", fd_front); end
    if (n >= 4) begin
      checks++; if (wa[0] !== {1'b1, 22'd1}) begin failures++; $display("FAIL drain_a0 got %h exp %h", wa[0], {1'b1, 22'd1}); end
      checks++; if (wa[2] !== {1'b1, 22'd3}) begin failures++; $display("FAIL drain_a2 got %h exp %h", wa[2], {1'b1, 22'd3}); end
      checks++; if (wa[3] !== {1'b0, 22'd5}) begin failures++; $display("FAIL drain_newbuf got %h exp %h", wa[3], {1'b0, 22'd5}); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    mem.fb_ack = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(i), 11'(i), 11'd0, 1'b0, 1'b1);
    checks++; if (mem.fb_we !== 1'b1) begin failures++; $display("FAIL mid_pending got we=%b exp 1", mem.fb_we); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem.fb_we !== 1'b0) begin failures++; $display("FAIL mid_we got %b exp 0", mem.fb_we); end
    checks++; if (front_buf !== 1'b0) begin failures++; $display("FAIL mid_front got %b exp 0", front_buf); end
    checks++; if (pix.in_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got %b exp 0", pix.in_ready); end
    reset = 1'b0; mem.fb_ack = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (mem.fb_we) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_flush got stale write exp none"); end
  endtask

  task automatic test_back_to_back();
    int fd = 0;
    logic f1 = 1'b0;
    send(8'h00, 11'd0, 11'd0, 1'b1, 1'b0);
    send(8'h00, 11'd0, 11'd0, 1'b1, 1'b0);
    for (int c = 0; c < 30; c++) begin
      if (frame_done) begin fd++; if (fd == 1) f1 = front_buf; end
      @(posedge clk); #1;
    end
    checks++; if (fd !== 2) begin failures++; $display("FAIL b2b_pulses got %0d exp 2", fd); end
    checks++; if (f1 !== 1'b1) begin failures++; $display("FAIL b2b_first_front got %b exp 1", f1); end
    checks++; if (front_buf !== 1'b0) begin failures++; $display("FAIL b2b_final_front got %b exp 0", front_buf); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_clip();
    test_backpressure();
    test_frame_drain();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
